purchase_sequencer: RTL and testbench
=====================================

PURCHASE_SEQUENCER -- requirements
Module: purchase_sequencer

Interface
REQ-001 The block SHALL provide parameter PRICE, default 5, coin pulses per purchase (legal range 1..7).
REQ-002 The block SHALL provide parameter GAP, default 2, idle cycles between consecutive coin pulses (legal range 0..15).
REQ-003 The block SHALL provide parameter TIMEOUT, default 16, maximum cycles dispense is held awaiting item_out (legal range 1..255).
REQ-004 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: buy_req  input  1  request one purchase; sampled only in IDLE.
REQ-007 Port: item_out  input  1  item-delivered indication from the vending machine.
REQ-008 Port: busy  output  1  high from the cycle after acceptance until return to IDLE.
REQ-009 Port: coin_in  output  1  coin pulse to the vending machine.
REQ-010 Port: dispense  output  1  dispense request to the vending machine, level-held.
REQ-011 Port: cancel  output  1  cancel pulse to the vending machine.
REQ-012 Port: done  output  1  one-cycle pulse, purchase succeeded.
REQ-013 Port: error  output  1  one-cycle pulse, purchase timed out and was cancelled.
REQ-014 Port: coins_sent  output  3  coins issued in the current purchase.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 States SHALL be IDLE, COIN, GAP, SETTLE, DISP and CANCEL.
REQ-017 IDLE: buy_req=1 SHALL move to COIN on the next edge, clearing coins_sent and setting busy; buy_req=0 SHALL stay in IDLE.
REQ-018 COIN: coin_in SHALL be 1 for exactly one cycle and coins_sent SHALL increment on leaving COIN.
REQ-019 After COIN, when coins_sent+1 equals PRICE the block SHALL go to SETTLE; otherwise to GAP (to COIN directly when GAP=0).
REQ-020 GAP: all handshake outputs low for exactly GAP cycles, then COIN.
REQ-021 SETTLE: all handshake outputs low for exactly 2 cycles, then DISP.
REQ-022 DISP: dispense SHALL be 1 every cycle in DISP; an internal wait counter SHALL count cycles in DISP.
REQ-023 DISP: item_out=1 SHALL drop dispense, pulse done for one cycle, and return to IDLE on the next edge.
REQ-024 DISP: TIMEOUT cycles elapsed with item_out=0 SHALL drop dispense and move to CANCEL.
REQ-025 CANCEL: cancel=1 and error=1 for exactly one cycle, then IDLE.
REQ-026 item_out=1 and timeout expiry in the same cycle SHALL be treated as success (done, no cancel).
REQ-027 buy_req SHALL be ignored while busy; item_out SHALL be ignored outside DISP.
REQ-028 coin_in, dispense and cancel SHALL be mutually exclusive in every cycle.
REQ-029 busy SHALL be 0 in the cycle done or error is high, so a new buy_req may be accepted the cycle after it.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE and busy, coin_in, dispense, cancel, done, error, coins_sent and all internal counters to 0, including mid-purchase.
REQ-031 The first edge after rst_n deasserts SHALL evaluate IDLE normally (buy_req held high is accepted).

Configuration
REQ-032 Macro PURCHASE_SEQ_STATS_EN defined SHALL add outputs ok_count[7:0] and err_count[7:0], incremented with done and error respectively, saturating at 255, reset to 0.
REQ-033 Macro PURCHASE_SEQ_STATS_EN undefined SHALL omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-034 Defaults, buy_req pulse in cycle 0, item_out returned 1 cycle after dispense rises -> coin_in high in cycles 1,4,7,10,13; dispense high from cycle 16; done in cycle 18; coins_sent=5.
REQ-035 Defaults, item_out never asserted -> dispense high for 16 cycles, then cancel=1 and error=1 for one cycle, then IDLE, busy=0.
REQ-036 GAP=0, PRICE=3 -> coin_in high in cycles 1,2,3; SETTLE 4-5; dispense from 6.
REQ-037 rst_n pulsed low during GAP after coin 3 -> all outputs 0 at once; next buy_req restarts at coins_sent=0.
REQ-038 buy_req held high throughout and item_out pulses ignored outside DISP -> back-to-back purchases, one done each, no extra coin_in.
REQ-039 With PURCHASE_SEQ_STATS_EN, 300 successful purchases -> ok_count=255, err_count=0.

Source files
------------

// File: rtl/purchase_sequencer_if.sv
// -----------------------------------------------------------------------------
// purchase_sequencer_if
//
// Purpose : bundles the purchase request / vending-machine handshake of
//           purchase_sequencer into one interface.
//
// Signals :
//   buy_req     requester -> sequencer   request one purchase
//   item_out    machine   -> sequencer   item delivered
//   busy        sequencer -> requester   purchase in progress
//   coin_in     sequencer -> machine     one coin pulse
//   dispense    sequencer -> machine     level-held dispense request
//   cancel      sequencer -> machine     cancel pulse after a timeout
//   done        sequencer -> requester   one-cycle success pulse
//   error       sequencer -> requester   one-cycle timeout/cancel pulse
//   coins_sent  sequencer -> requester   coins issued in the current purchase
//   ok_count    sequencer -> requester   saturating success count   (PURCHASE_SEQ_STATS_EN)
//   err_count   sequencer -> requester   saturating error count     (PURCHASE_SEQ_STATS_EN)
//
// Modports:
//   master  the sequencer side (drives busy/coin_in/.../coins_sent)
//   slave   the requester / vending-machine side (drives buy_req, item_out)
//
// Configuration macro: PURCHASE_SEQ_STATS_EN adds ok_count / err_count.
// -----------------------------------------------------------------------------
interface purchase_sequencer_if;
    logic       buy_req;
    logic       item_out;
    logic       busy;
    logic       coin_in;
    logic       dispense;
    logic       cancel;
    logic       done;
    logic       error;
    logic [2:0] coins_sent;
`ifdef PURCHASE_SEQ_STATS_EN
    logic [7:0] ok_count;
    logic [7:0] err_count;

    modport master (
        input  buy_req, item_out,
        output busy, coin_in, dispense, cancel, done, error, coins_sent,
        output ok_count, err_count
    );

    modport slave (
        output buy_req, item_out,
        input  busy, coin_in, dispense, cancel, done, error, coins_sent,
        input  ok_count, err_count
    );
`else
    modport master (
        input  buy_req, item_out,
        output busy, coin_in, dispense, cancel, done, error, coins_sent
    );

    modport slave (
        output buy_req, item_out,
        input  busy, coin_in, dispense, cancel, done, error, coins_sent
    );
`endif
endinterface : purchase_sequencer_if

// File: rtl/purchase_sequencer.sv
// -----------------------------------------------------------------------------
// purchase_sequencer
//
// Purpose : drives one vending-machine purchase per accepted buy_req.
//           Issues PRICE coin pulses separated by GAP idle cycles, lets the
//           machine settle for two cycles, then holds dispense until the
//           machine reports item_out or TIMEOUT cycles elapse. A timeout is
//           answered with a one-cycle cancel/error pulse.
//
// Parameters:
//   PRICE    coin pulses per purchase            (1..7,   default 5)
//   GAP      idle cycles between coin pulses     (0..15,  default 2)
//   TIMEOUT  max cycles dispense is held         (1..255, default 16)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    purchase_sequencer_if.master (buy_req, item_out in;
//          busy, coin_in, dispense, cancel, done, error, coins_sent out;
//          ok_count, err_count out when PURCHASE_SEQ_STATS_EN is defined)
//
// Configuration macro: PURCHASE_SEQ_STATS_EN adds saturating success / error
// counters. Without it those ports and counters do not exist.
//
// Every output is a flop; the output flops are loaded from the *next* state,
// so each output is valid in the same cycle the state register shows that
// state, with no combinational path from any input.
// -----------------------------------------------------------------------------
module purchase_sequencer #(
    parameter int PRICE   = 5,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    purchase_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COIN   = 3'd1,
        ST_GAP    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DISP   = 3'd4,
        ST_CANCEL = 3'd5
    } state_e;

    // ---------------------------------------------------------------------
    // State and counters
    // ---------------------------------------------------------------------
    state_e     state_q,      state_d;
    logic [2:0] coins_sent_q, coins_sent_d;
    logic [3:0] gap_cnt_q,    gap_cnt_d;     // cycles already spent in GAP
    logic       settle_cnt_q, settle_cnt_d;  // cycles already spent in SETTLE
    logic [7:0] wait_cnt_q,   wait_cnt_d;    // cycles already spent in DISP

    // Registered outputs
    logic busy_q,     busy_d;
    logic coin_in_q,  coin_in_d;
    logic dispense_q, dispense_d;
    logic cancel_q,   cancel_d;
    logic done_q,     done_d;
    logic error_q,    error_d;

    // Terminal-count conditions, evaluated against the current count
    logic last_coin;
    logic gap_over;
    logic wait_over;

    assign last_coin = (int'(coins_sent_q) + 1) == PRICE;
    assign gap_over  = (int'(gap_cnt_q)    + 1) == GAP;
    assign wait_over = (int'(wait_cnt_q)   + 1) == TIMEOUT;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        coins_sent_d = coins_sent_q;
        gap_cnt_d    = gap_cnt_q;
        settle_cnt_d = settle_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        done_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.buy_req) begin
                    state_d      = ST_COIN;
                    coins_sent_d = '0;
                end
            end

            ST_COIN: begin
                coins_sent_d = coins_sent_q + 3'd1;
                if (last_coin) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 1'b0;
                end else if (GAP == 0) begin
                    state_d = ST_COIN;
                end else begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end
            end

            ST_GAP: begin
                if (gap_over) begin
                    state_d = ST_COIN;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            ST_SETTLE: begin
                // Two cycles: the first sets the flag, the second leaves.
                if (settle_cnt_q) begin
                    state_d    = ST_DISP;
                    wait_cnt_d = '0;
                end else begin
                    settle_cnt_d = 1'b1;
                end
            end

            ST_DISP: begin
                // item_out wins over a timeout landing in the same cycle.
                if (bus.item_out) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (wait_over) begin
                    state_d = ST_CANCEL;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            ST_CANCEL: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered, so they line up with it.
        // busy is already low in the CANCEL (error) cycle and in the IDLE
        // cycle that carries done.
        busy_d     = (state_d == ST_COIN)   || (state_d == ST_GAP) ||
                     (state_d == ST_SETTLE) || (state_d == ST_DISP);
        coin_in_d  = (state_d == ST_COIN);
        dispense_d = (state_d == ST_DISP);
        cancel_d   = (state_d == ST_CANCEL);
        error_d    = (state_d == ST_CANCEL);
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            coins_sent_q <= '0;
            gap_cnt_q    <= '0;
            settle_cnt_q <= 1'b0;
            wait_cnt_q   <= '0;
            busy_q       <= 1'b0;
            coin_in_q    <= 1'b0;
            dispense_q   <= 1'b0;
            cancel_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            coins_sent_q <= coins_sent_d;
            gap_cnt_q    <= gap_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            busy_q       <= busy_d;
            coin_in_q    <= coin_in_d;
            dispense_q   <= dispense_d;
            cancel_q     <= cancel_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.coin_in    = coin_in_q;
    assign bus.dispense   = dispense_q;
    assign bus.cancel     = cancel_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.coins_sent = coins_sent_q;

`ifdef PURCHASE_SEQ_STATS_EN
    // ---------------------------------------------------------------------
    // Saturating purchase statistics, stepped together with done / error
    // ---------------------------------------------------------------------
    logic [7:0] ok_count_q,  ok_count_d;
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        ok_count_d  = ok_count_q;
        err_count_d = err_count_q;
        if (done_d && (ok_count_q != 8'hFF)) begin
            ok_count_d = ok_count_q + 8'd1;
        end
        if (error_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            ok_count_q  <= ok_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.ok_count  = ok_count_q;
    assign bus.err_count = err_count_q;
`endif

endmodule : purchase_sequencer

// File: tb/tb_purchase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_purchase_sequencer
//
// Two sequencers share one stimulus stream: u0 with default parameters and
// u1 with PRICE=3, GAP=0, TIMEOUT=4. Expected outputs come from a schedule
// model: once a purchase is accepted at cycle a, coin k (0-based) falls at
// a+1+k*(GAP+1), dispense starts at a+(PRICE-1)*(GAP+1)+4, and the purchase
// ends on the first sampled item_out in that window or after TIMEOUT cycles.
// Outputs are compared 1 time unit after every rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_purchase_sequencer;

    localparam int N_CYC = 5400;

    logic clk;
    logic rst_n;
    logic buy_req;
    logic item_out;

    purchase_sequencer_if bus0 ();
    purchase_sequencer_if bus1 ();

    assign bus0.buy_req  = buy_req;
    assign bus0.item_out = item_out;
    assign bus1.buy_req  = buy_req;
    assign bus1.item_out = item_out;

    purchase_sequencer u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    purchase_sequencer #(
        .PRICE   (3),
        .GAP     (0),
        .TIMEOUT (4)
    ) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int i,
                         input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s u%0d @%0t: got %0d, expected %0d", name, i, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Sampled DUT outputs
    // ------------------------------------------------------------------
    logic       a_busy[2], a_coin[2], a_disp[2], a_cancel[2], a_done[2], a_err[2];
    logic [2:0] a_coins[2];
    logic [7:0] a_okc[2], a_errc[2];

    task automatic sample();
        a_busy[0] = bus0.busy;     a_busy[1] = bus1.busy;
        a_coin[0] = bus0.coin_in;  a_coin[1] = bus1.coin_in;
        a_disp[0] = bus0.dispense; a_disp[1] = bus1.dispense;
        a_cancel[0] = bus0.cancel; a_cancel[1] = bus1.cancel;
        a_done[0] = bus0.done;     a_done[1] = bus1.done;
        a_err[0]  = bus0.error;    a_err[1]  = bus1.error;
        a_coins[0] = bus0.coins_sent; a_coins[1] = bus1.coins_sent;
`ifdef PURCHASE_SEQ_STATS_EN
        a_okc[0] = bus0.ok_count;  a_okc[1] = bus1.ok_count;
        a_errc[0] = bus0.err_count; a_errc[1] = bus1.err_count;
`else
        a_okc[0] = '0; a_okc[1] = '0; a_errc[0] = '0; a_errc[1] = '0;
`endif
    endtask

    // ------------------------------------------------------------------
    // Schedule model
    // ------------------------------------------------------------------
    int P[2] = '{5, 3};
    int G[2] = '{2, 0};
    int T[2] = '{16, 4};

    bit m_active[2];
    int m_acc[2];
    int m_ds[2];
    int e_busy[2], e_coin[2], e_disp[2], e_cancel[2], e_done[2], e_err[2];
    int e_coins[2], e_okc[2], e_errc[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_acc[i] = 0; m_ds[i] = 0;
            e_busy[i] = 0; e_coin[i] = 0; e_disp[i] = 0; e_cancel[i] = 0;
            e_done[i] = 0; e_err[i] = 0; e_coins[i] = 0; e_okc[i] = 0; e_errc[i] = 0;
        end
    endtask

    // Consume the inputs of cycle c and produce expectations for cycle c+1.
    task automatic model_step(input int c, input bit buy, input bit item);
        for (int i = 0; i < 2; i++) begin
            int  m   = c + 1;
            bit  nd  = 1'b0;
            bit  ne  = 1'b0;
            bit  in_cancel = (e_err[i] != 0);
            if (m_active[i]) begin
                if (c >= m_ds[i]) begin
                    if (item) begin
                        nd = 1'b1; m_active[i] = 1'b0;
                    end else if (c - m_ds[i] + 1 == T[i]) begin
                        ne = 1'b1; m_active[i] = 1'b0;
                    end
                end
            end else if (!in_cancel && buy) begin
                m_active[i] = 1'b1;
                m_acc[i]    = c;
                m_ds[i]     = c + (P[i] - 1) * (G[i] + 1) + 4;
            end
            e_done[i]   = nd;
            e_err[i]    = ne;
            e_cancel[i] = ne;
            e_busy[i]   = m_active[i];
            if (m_active[i]) begin
                int off = m - m_acc[i];
                e_coin[i] = (off >= 1 && (off - 1) % (G[i] + 1) == 0 &&
                             (off - 1) / (G[i] + 1) < P[i]) ? 1 : 0;
                e_disp[i] = (m >= m_ds[i]) ? 1 : 0;
                if (off <= 1) e_coins[i] = 0;
                else begin
                    e_coins[i] = (off - 2) / (G[i] + 1) + 1;
                    if (e_coins[i] > P[i]) e_coins[i] = P[i];
                end
            end else begin
                e_coin[i] = 0;
                e_disp[i] = 0;
            end
            if (nd && e_okc[i] < 255)  e_okc[i]++;
            if (ne && e_errc[i] < 255) e_errc[i]++;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check("busy",       i, 32'(a_busy[i]),   e_busy[i]);
            check("coin_in",    i, 32'(a_coin[i]),   e_coin[i]);
            check("dispense",   i, 32'(a_disp[i]),   e_disp[i]);
            check("cancel",     i, 32'(a_cancel[i]), e_cancel[i]);
            check("done",       i, 32'(a_done[i]),   e_done[i]);
            check("error",      i, 32'(a_err[i]),    e_err[i]);
            check("coins_sent", i, 32'(a_coins[i]),  e_coins[i]);
            check("exclusive",  i, 32'((32'(a_coin[i]) + 32'(a_disp[i]) + 32'(a_cancel[i])) <= 1), 1);
`ifdef PURCHASE_SEQ_STATS_EN
            check("ok_count",   i, 32'(a_okc[i]),    e_okc[i]);
            check("err_count",  i, 32'(a_errc[i]),   e_errc[i]);
`endif
        end
    endtask

    task automatic check_all_zero(input string tag);
        sample();
        for (int i = 0; i < 2; i++) begin
            check({tag, "_busy"},     i, 32'(a_busy[i]),   0);
            check({tag, "_coin_in"},  i, 32'(a_coin[i]),   0);
            check({tag, "_dispense"}, i, 32'(a_disp[i]),   0);
            check({tag, "_cancel"},   i, 32'(a_cancel[i]), 0);
            check({tag, "_done"},     i, 32'(a_done[i]),   0);
            check({tag, "_error"},    i, 32'(a_err[i]),    0);
            check({tag, "_coins"},    i, 32'(a_coins[i]),  0);
`ifdef PURCHASE_SEQ_STATS_EN
            check({tag, "_okc"},      i, 32'(a_okc[i]),    0);
            check({tag, "_errc"},     i, 32'(a_errc[i]),   0);
`endif
        end
    endtask

    // Hand-computed expectations for the directed opening scenarios.
    task automatic literal_checks(input int c);
        if (c >= 1 && c <= 19) begin
            check("lit_coin",  0, 32'(a_coin[0]),
                  (c == 1 || c == 4 || c == 7 || c == 10 || c == 13) ? 1 : 0);
            check("lit_disp",  0, 32'(a_disp[0]), (c == 16 || c == 17) ? 1 : 0);
            check("lit_done",  0, 32'(a_done[0]), (c == 18) ? 1 : 0);
        end
        if (c == 18) begin
            check("lit_coins5",   0, 32'(a_coins[0]), 5);
            check("lit_busy_done", 0, 32'(a_busy[0]), 0);
        end
        if (c >= 1 && c <= 12) begin
            check("lit_coin",   1, 32'(a_coin[1]),   (c >= 1 && c <= 3) ? 1 : 0);
            check("lit_disp",   1, 32'(a_disp[1]),   (c >= 6 && c <= 9) ? 1 : 0);
            check("lit_cancel", 1, 32'(a_cancel[1]), (c == 10) ? 1 : 0);
        end
        if (c == 35) check("lit_disp_pre",   0, 32'(a_disp[0]), 0);
        if (c == 36) check("lit_disp_first", 0, 32'(a_disp[0]), 1);
        if (c == 51) check("lit_disp_last",  0, 32'(a_disp[0]), 1);
        if (c == 52) begin
            check("lit_to_cancel", 0, 32'(a_cancel[0]), 1);
            check("lit_to_error",  0, 32'(a_err[0]),    1);
            check("lit_to_disp",   0, 32'(a_disp[0]),   0);
            check("lit_to_busy",   0, 32'(a_busy[0]),   0);
        end
        if (c == 53) check("lit_idle_busy", 0, 32'(a_busy[0]), 0);
        if (c == 68) check("lit_gap_coins3", 0, 32'(a_coins[0]), 3);
        if (c == 73) begin
            check("lit_restart_coin",  0, 32'(a_coin[0]),  1);
            check("lit_restart_coins", 0, 32'(a_coins[0]), 0);
        end
        if (c == 74) check("lit_restart_coins1", 0, 32'(a_coins[0]), 1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n    = 1'b0;
        buy_req  = 1'b0;
        item_out = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            sample();
            compare_all();
            literal_checks(cyc);

            // Asynchronous reset mid-purchase (first one lands in u0's GAP
            // after its third coin), released on the falling edge.
            if (cyc == 68 || cyc == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                check_all_zero("midrst");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end

            if (cyc < 100) begin
                buy_req  = (cyc == 0 || cyc == 20 || cyc == 60 || cyc == 72);
                item_out = (cyc == 17);
            end else if (cyc < 3000) begin
                buy_req  = ($urandom % 4) == 0;
                item_out = ($urandom % 10) == 0;
            end else begin
                buy_req  = 1'b1;
                item_out = 1'b1;
            end
            model_step(cyc, buy_req, item_out);
        end

`ifdef PURCHASE_SEQ_STATS_EN
        @(posedge clk);
        #1;
        sample();
        check("lit_ok_sat", 1, 32'(a_okc[1]), 255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_purchase_sequencer
